// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage_pkg
// Brief    : Shared constants, ALU opcodes and ID/EX control bundle for the
//            8-bit pipelined core operand stage.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_operand_stage_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_RA_W   = 3;
    localparam int ALU_W      = 4;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'h7;
    localparam logic [ALU_W-1:0] ALU_PASS = 4'h8;

    // Control bundle carried from decode into the execute stage
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic [ALU_W-1:0] alu_ctrl;
    } idex_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage_fwd_mux
// Brief    : Three-way operand forward select (EX/MEM > MEM/WB > latched).
//            Register 0 never forwards.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RA_W   = DEF_RA_W
) (
    input  logic [RA_W-1:0]   src_i,
    input  logic [DATA_W-1:0] latched_i,
    input  logic              exm_reg_write_i,
    input  logic [RA_W-1:0]   exm_rd_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              wb_reg_write_i,
    input  logic [RA_W-1:0]   wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] value_o
);

    // Youngest producer wins; R0 always uses the latched (zero) value
    always_comb begin
        value_o = latched_i;
        if (src_i != '0) begin
            if (exm_reg_write_i && (exm_rd_i == src_i)) begin
                value_o = exm_result_i;
            end else if (wb_reg_write_i && (wb_rd_i == src_i)) begin
                value_o = wb_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX pipeline register with write-back bypass at capture,
//            EX/MEM and MEM/WB operand forwarding, load-use stall detection
//            and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RA_W        = DEF_RA_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [DATA_W-1:0]      id_rd1,
    input  logic [DATA_W-1:0]      id_rd2,
    input  logic [DATA_W-1:0]      id_imm,
    input  logic [RA_W-1:0]        id_rs1,
    input  logic [RA_W-1:0]        id_rs2,
    input  logic [RA_W-1:0]        id_rd,
    input  logic [3:0]             id_alu_ctrl,
    input  logic                   id_alu_src,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic                   flush,
    input  logic                   exm_reg_write,
    input  logic [RA_W-1:0]        exm_rd,
    input  logic [DATA_W-1:0]      exm_result,
    input  logic                   wb_reg_write,
    input  logic [RA_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   stall,
    output logic [DATA_W-1:0]      src_a,
    output logic [DATA_W-1:0]      src_b,
    output logic [3:0]             alu_control,
    output logic                   ex_valid,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic [RA_W-1:0]        ex_rd,
    output logic [DATA_W-1:0]      ex_store_data,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] c_cnt_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    idex_ctrl_t              ctrl_q, ctrl_d;
    logic [RA_W-1:0]         rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0]       rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    w_stall;
    logic [DATA_W-1:0]       w_fwd_a, w_fwd_b;

    // Load-use hazard: a load in EX feeds a register the decode instruction reads
    always_comb begin
        w_stall = !flush && id_valid && ctrl_q.valid && ctrl_q.mem_read &&
                  (rd_q != '0) &&
                  ((rd_q == id_rs1) ||
                   ((rd_q == id_rs2) && (!id_alu_src || id_mem_write)));
    end

    // Next ID/EX contents: bubble on flush or stall, otherwise capture decode
    always_comb begin
        ctrl_d = '0;
        rd_d   = '0;
        rs1_d  = '0;
        rs2_d  = '0;
        rd1_d  = '0;
        rd2_d  = '0;
        imm_d  = '0;
        if (!flush && !w_stall) begin
            ctrl_d.valid     = id_valid;
            ctrl_d.reg_write = id_valid & id_reg_write;
            ctrl_d.mem_read  = id_valid & id_mem_read;
            ctrl_d.mem_write = id_valid & id_mem_write;
            ctrl_d.alu_src   = id_alu_src;
            ctrl_d.alu_ctrl  = id_alu_ctrl;
            rd_d             = id_rd;
            rs1_d            = id_rs1;
            rs2_d            = id_rs2;
            imm_d            = id_imm;
            // Register file is written and read in the same cycle: take the WB value
            rd1_d = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rd1;
            rd2_d = (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rd2;
        end
        cnt_d = cnt_q;
        if (w_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + c_cnt_one;
        end
    end

    // ID/EX register and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            cnt_q  <= cnt_d;
        end
    end

    id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
        .src_i           (rs1_q),
        .latched_i       (rd1_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_data_i       (wb_data),
        .value_o         (w_fwd_a)
    );

    id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
        .src_i           (rs2_q),
        .latched_i       (rd2_q),
        .exm_reg_write_i (exm_reg_write),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_rd_i         (wb_rd),
        .wb_data_i       (wb_data),
        .value_o         (w_fwd_b)
    );

    // Execute-stage outputs
    always_comb begin
        stall         = w_stall;
        src_a         = w_fwd_a;
        src_b         = ctrl_q.alu_src ? imm_q : w_fwd_b;
        ex_store_data = w_fwd_b;
        alu_control   = ctrl_q.alu_ctrl;
        ex_valid      = ctrl_q.valid;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_rd         = rd_q;
        stall_count   = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Brief    : Scoreboard testbench for id_ex_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    // Narrow counter so the saturation scenario stays short
    localparam int CW = 8;
    localparam logic [CW-1:0] c_cnt_max = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [7:0]    id_rd1, id_rd2, id_imm;
    logic [2:0]    id_rs1, id_rs2, id_rd;
    logic [3:0]    id_alu_ctrl;
    logic          id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic          flush;
    logic          exm_reg_write;
    logic [2:0]    exm_rd;
    logic [7:0]    exm_result;
    logic          wb_reg_write;
    logic [2:0]    wb_rd;
    logic [7:0]    wb_data;
    logic          stall;
    logic [7:0]    src_a, src_b, ex_store_data;
    logic [3:0]    alu_control;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]    ex_rd;
    logic [CW-1:0] stall_count;

    int            n_run  = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sd;
        logic [3:0] alu;
        logic       v;
        logic       rw;
        logic       mr;
        logic       mw;
        logic [2:0] rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t e, o;

    id_ex_operand_stage #(.DATA_W(8), .RA_W(3), .STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sd,
                                input logic [3:0] alu, input logic v, input logic rw,
                                input logic mr, input logic mw, input logic [2:0] rd);
        mk = '{a, b, sd, alu, v, rw, mr, mw, rd};
    endfunction

    function automatic exp_t obs();
        obs = '{src_a, src_b, ex_store_data, alu_control, ex_valid,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                            input logic [2:0] rd, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] imm, input logic [3:0] alu, input logic src,
                            input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = d1; id_rd2 = d2; id_imm = imm; id_alu_ctrl = alu;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic fwd_idle();
        exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        fwd_idle();
        drive_id(1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom));
        sb_q.push_back('0);
        tick();
        tick();
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", o, e); end
        n_run++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
        n_run++;
        if (stall_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", stall_count); end
        reset = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_cnt = '0;
        tick();
    endtask

    task automatic test_ex_forward();
        drive_id(1, 3, 5, 1, 8'h22, 8'h33, 8'h00, ALU_ADD, 0, 1, 0, 0);
        sb_q.push_back(mk(8'h5A, 8'h33, 8'h33, ALU_ADD, 1, 1, 0, 0, 3'd1));
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exm_reg_write = 1'b1; exm_rd = 3'd3; exm_result = 8'h5A;
        wb_reg_write = 1'b1; wb_rd = 3'd3; wb_data = 8'h11;
        #1;
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL fwd_exm_priority: got %h required %h", o, e); end
        exm_reg_write = 1'b0;
        #1; n_run++;
        if (src_a !== 8'h11) begin n_fail++; $display("FAIL fwd_wb: got %h required 11", src_a); end
        wb_reg_write = 1'b0;
        #1; n_run++;
        if (src_a !== 8'h22) begin n_fail++; $display("FAIL fwd_none: got %h required 22", src_a); end
        exm_reg_write = 1'b1; exm_rd = 3'd5;
        #1; n_run++;
        if ({src_b, ex_store_data} !== 16'h5A5A) begin
            n_fail++; $display("FAIL fwd_rs2: got %h/%h required 5a/5a", src_b, ex_store_data);
        end
        fwd_idle();
        tick();
    endtask

    task automatic test_load_use();
        drive_id(1, 0, 0, 2, 8'h00, 8'h00, 8'h04, ALU_ADD, 1, 1, 1, 0);
        sb_q.push_back(mk(8'h00, 8'h04, 8'h00, ALU_ADD, 1, 1, 1, 0, 3'd2));
        tick();
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL load_capture: got %h required %h", o, e); end
        drive_id(1, 2, 6, 3, 8'h21, 8'h62, 8'h00, ALU_SUB, 0, 1, 0, 0);
        #1; n_run++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b required 1", stall); end
        sb_q.push_back('0);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL load_use_bubble: got %h required %h", o, e); end
        n_run++;
        if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL load_use_count: got %0d required %0d", stall_count, exp_cnt); end
        n_run++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b required 0", stall); end
        sb_q.push_back(mk(8'h21, 8'h62, 8'h62, ALU_SUB, 1, 1, 0, 0, 3'd3));
        tick();
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL load_use_replay: got %h required %h", o, e); end
    endtask

    task automatic test_flush();
        drive_id(1, 0, 0, 2, 8'h00, 8'h00, 8'h04, ALU_ADD, 1, 1, 1, 0);
        tick();
        drive_id(1, 2, 6, 3, 8'h21, 8'h62, 8'h00, ALU_SUB, 0, 1, 0, 0);
        flush = 1'b1;
        #1; n_run++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b required 0", stall); end
        sb_q.push_back('0);
        tick();
        flush = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL flush_bubble: got %h required %h", o, e); end
        n_run++;
        if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL flush_count: got %0d required %0d", stall_count, exp_cnt); end
    endtask

    task automatic test_wb_bypass();
        drive_id(1, 1, 4, 6, 8'h10, 8'h00, 8'hAA, ALU_OR, 0, 1, 0, 0);
        wb_reg_write = 1'b1; wb_rd = 3'd4; wb_data = 8'h7F;
        sb_q.push_back(mk(8'h10, 8'h7F, 8'h7F, ALU_OR, 1, 1, 0, 0, 3'd6));
        tick();
        fwd_idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL wb_bypass: got %h required %h", o, e); end
    endtask

    task automatic test_r0_imm();
        drive_id(1, 0, 5, 7, 8'h3C, 8'h44, 8'hF0, ALU_XOR, 1, 1, 0, 0);
        wb_reg_write = 1'b1; wb_rd = 3'd0; wb_data = 8'hEE;
        sb_q.push_back(mk(8'h3C, 8'hF0, 8'h44, ALU_XOR, 1, 1, 0, 0, 3'd7));
        tick();
        fwd_idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exm_reg_write = 1'b1; exm_rd = 3'd0; exm_result = 8'h99;
        #1;
        e = sb_q.pop_front(); o = obs(); n_run++;
        if (o !== e) begin n_fail++; $display("FAIL r0_no_forward: got %h required %h", o, e); end
        exm_rd = 3'd5;
        #1; n_run++;
        if (src_b !== 8'hF0) begin n_fail++; $display("FAIL imm_over_fwd: got %h required f0", src_b); end
        n_run++;
        if (ex_store_data !== 8'h99) begin n_fail++; $display("FAIL store_fwd: got %h required 99", ex_store_data); end
        fwd_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2, im;
        logic       s, mw;
        for (int i = 0; i < 4; i++) begin
            d1 = 8'($urandom); d2 = 8'($urandom); im = 8'($urandom);
            s = 1'($urandom); mw = 1'($urandom);
            drive_id(1, 3'(i + 1), 3'(i + 2), 3'(7 - i), d1, d2, im, 4'(i + 2), s, ~mw, 0, mw);
            sb_q.push_back(mk(d1, s ? im : d2, d2, 4'(i + 2), 1, ~mw, 0, mw, 3'(7 - i)));
            tick();
            e = sb_q.pop_front(); o = obs(); n_run++;
            if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h required %h", i, o, e); end
        end
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            drive_id(1, 0, 0, 2, 8'h00, 8'h00, 8'h04, ALU_ADD, 1, 1, 1, 0);
            tick();
            drive_id(1, 1, 2, 3, 8'h00, 8'h00, 8'h00, ALU_ADD, 0, 1, 0, 0);
            tick();
            if (exp_cnt != c_cnt_max) exp_cnt = exp_cnt + 1'b1;
            if (i == 100) begin
                n_run++;
                if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL count_mid: got %0d required %0d", stall_count, exp_cnt); end
            end
        end
        n_run++;
        if (stall_count !== 8'hFF) begin n_fail++; $display("FAIL count_saturate: got %0d required 255", stall_count); end
        drive_id(1, 0, 0, 2, 8'h00, 8'h00, 8'h04, ALU_ADD, 1, 1, 1, 0);
        tick();
        drive_id(1, 2, 0, 3, 8'h00, 8'h00, 8'h00, ALU_ADD, 0, 1, 0, 0);
        reset = 1'b1;
        tick();
        n_run++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall: got %b required 0", stall); end
        n_run++;
        if (stall_count !== '0) begin n_fail++; $display("FAIL reset_mid_count: got %0d required 0", stall_count); end
        reset = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_flush();
        test_wb_bypass();
        test_r0_imm();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
